// File: rtl/cordic_ctrl.sv
// Request-side controller for the iterative 16-bit CORDIC core: sanitises operands,
// resolves degenerate jobs locally, runs the core under a watchdog and returns the result.
module cordic_ctrl #(
  parameter int TIMEOUT = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [15:0] in_z,
  output logic        core_hold,
  output logic        core_is_direct,
  output logic [15:0] core_x,
  output logic [15:0] core_y,
  output logic [15:0] core_z,
  input  logic        core_valid,
  input  logic [15:0] core_x_res,
  input  logic [15:0] core_y_res,
  input  logic [15:0] core_z_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic [15:0] out_z,
  output logic        out_bypass,
  output logic        out_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid and its payload stay stable until that edge.

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic signed [16:0] PI_W     = 17'sd25736;
  localparam logic signed [16:0] TWO_PI_W = 17'sd51472;
  localparam logic [15:0] PI_Q          = 16'd25736;
  localparam logic [15:0] PI_HALF_Q     = 16'd12868;
  localparam logic [15:0] NEG_PI_HALF_Q = 16'd52668;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_e;

  state_e state_q, state_d;

  logic            op_mode_q, op_mode_d;
  logic [15:0]     op_x_q, op_x_d, op_y_q, op_y_d, op_z_q, op_z_d;
  logic            core_hold_q, core_hold_d;
  logic            core_dir_q, core_dir_d;
  logic [15:0]     core_x_q, core_x_d, core_y_q, core_y_d, core_z_q, core_z_d;
  logic [15:0]     out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
  logic            out_bypass_q, out_bypass_d;
  logic            out_err_q, out_err_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic signed [16:0] z_wide, z_wrap;
  logic               x_zero, y_zero, launch_job, wd_done;
  logic [15:0]        byp_x, byp_y, byp_z;

  // Negation never overflows: the most negative code maps to the most positive one.
  function automatic logic [15:0] sat_neg(input logic [15:0] v);
    return (v == 16'h8000) ? 16'h7fff : (~v + 16'd1);
  endfunction

  always_comb begin : classify
    z_wide = {in_z[15], in_z};
    z_wrap = z_wide;
    if (z_wide >= PI_W) begin
      z_wrap = z_wide - TWO_PI_W;
    end else if (z_wide <= -PI_W) begin
      z_wrap = z_wide + TWO_PI_W;
    end
    x_zero     = (in_x == 16'd0);
    y_zero     = (in_y == 16'd0);
    launch_job = 1'b1;
    byp_x      = 16'd0;
    byp_y      = 16'd0;
    byp_z      = 16'd0;
    if (in_mode) begin
      if ((z_wrap == PI_W) || (z_wrap == -PI_W)) begin
        launch_job = 1'b0;
        byp_x      = sat_neg(in_x);
        byp_y      = sat_neg(in_y);
      end
    end else if (x_zero) begin
      launch_job = 1'b0;
      if (!y_zero && !in_y[15]) begin
        byp_x = in_y;
        byp_z = PI_HALF_Q;
      end else if (in_y[15]) begin
        byp_x = sat_neg(in_y);
        byp_z = NEG_PI_HALF_Q;
      end
    end else if (in_x[15] && y_zero) begin
      launch_job = 1'b0;
      byp_x      = sat_neg(in_x);
      byp_z      = PI_Q;
    end
  end

  assign wd_done = (wd_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin : state_reg
    if (!reset) begin
      state_q      <= IDLE;
      op_mode_q    <= 1'b0;
      op_x_q       <= '0;
      op_y_q       <= '0;
      op_z_q       <= '0;
      core_hold_q  <= 1'b1;
      core_dir_q   <= 1'b0;
      core_x_q     <= '0;
      core_y_q     <= '0;
      core_z_q     <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_z_q      <= '0;
      out_bypass_q <= 1'b0;
      out_err_q    <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      op_mode_q    <= op_mode_d;
      op_x_q       <= op_x_d;
      op_y_q       <= op_y_d;
      op_z_q       <= op_z_d;
      core_hold_q  <= core_hold_d;
      core_dir_q   <= core_dir_d;
      core_x_q     <= core_x_d;
      core_y_q     <= core_y_d;
      core_z_q     <= core_z_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_z_q      <= out_z_d;
      out_bypass_q <= out_bypass_d;
      out_err_q    <= out_err_d;
      wd_q         <= wd_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = launch_job ? LAUNCH : DONE;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (core_valid || wd_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : datapath
    op_mode_d    = op_mode_q;
    op_x_d       = op_x_q;
    op_y_d       = op_y_q;
    op_z_d       = op_z_q;
    core_hold_d  = core_hold_q;
    core_dir_d   = core_dir_q;
    core_x_d     = core_x_q;
    core_y_d     = core_y_q;
    core_z_d     = core_z_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_z_d      = out_z_q;
    out_bypass_d = out_bypass_q;
    out_err_d    = out_err_q;
    wd_d         = wd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_mode_d    = in_mode;
          op_x_d       = in_x;
          op_y_d       = in_y;
          op_z_d       = in_mode ? z_wrap[15:0] : in_z;
          out_err_d    = 1'b0;
          out_bypass_d = !launch_job;
          if (!launch_job) begin
            out_x_d = byp_x;
            out_y_d = byp_y;
            out_z_d = byp_z;
          end
        end
      end
      LAUNCH: begin
        core_dir_d  = op_mode_q;
        core_x_d    = op_x_q;
        core_y_d    = op_y_q;
        core_z_d    = op_z_q;
        core_hold_d = 1'b0;
        wd_d        = '0;
      end
      WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // A result arriving on the timeout edge still counts as a success.
        if (core_valid) begin
          out_x_d     = core_x_res;
          out_y_d     = core_y_res;
          out_z_d     = core_z_res;
          core_hold_d = 1'b1;
        end else if (wd_done) begin
          out_x_d     = '0;
          out_y_d     = '0;
          out_z_d     = '0;
          out_err_d   = 1'b1;
          core_hold_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_bypass_d = 1'b0;
          out_err_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin : outputs
    in_ready       = (state_q == IDLE);
    out_valid      = (state_q == DONE);
    core_hold      = core_hold_q;
    core_is_direct = core_dir_q;
    core_x         = core_x_q;
    core_y         = core_y_q;
    core_z         = core_z_q;
    out_x          = out_x_q;
    out_y          = out_y_q;
    out_z          = out_z_q;
    out_bypass     = out_bypass_q;
    out_err        = out_err_q;
  end

endmodule

// File: tb/tb_cordic_ctrl.sv
// Directed bench for cordic_ctrl: drives jobs, models the CORDIC core's valid timing,
// and checks latency, sanitised operands, bypass results and the watchdog.
module tb_cordic_ctrl;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_mode;
  logic [15:0] in_x, in_y, in_z;
  logic        core_hold, core_is_direct;
  logic [15:0] core_x, core_y, core_z;
  logic        core_valid;
  logic [15:0] core_x_res, core_y_res, core_z_res;
  logic        out_valid, out_ready;
  logic [15:0] out_x, out_y, out_z;
  logic        out_bypass, out_err;

  int checks = 0;
  int errors = 0;

  cordic_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .core_hold(core_hold), .core_is_direct(core_is_direct),
    .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_valid(core_valid),
    .core_x_res(core_x_res), .core_y_res(core_y_res), .core_z_res(core_z_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_bypass(out_bypass), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Offers one job; the posedge inside is the accept edge E. Returns at the negedge after E.
  task automatic send_job(input logic mode, input logic [15:0] x, y, z, output bit acc_ok);
    @(negedge clk);
    in_mode  = mode;
    in_x     = x;
    in_y     = y;
    in_z     = z;
    in_valid = 1'b1;
    acc_ok   = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Core model: raises core_valid so it is sampled on the resp_at-th edge after release
  // (0 = never). lat counts edges from E up to the first negedge showing out_valid.
  task automatic run_core(input int resp_at, input logic [15:0] rx, ry, rz,
                          output int lat, output logic [48:0] seen,
                          output bit stable, output bit busy_ok, output bit released);
    int rel;
    lat = 1; rel = 0; stable = 1; busy_ok = 1; released = 0; seen = '0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 0;
      if (!core_hold) begin
        rel++;
        if (!released) begin
          seen     = {core_is_direct, core_x, core_y, core_z};
          released = 1;
        end else if ({core_is_direct, core_x, core_y, core_z} !== seen) begin
          stable = 0;
        end
        if (resp_at != 0 && rel == resp_at) begin
          core_valid = 1'b1;
          core_x_res = rx;
          core_y_res = ry;
          core_z_res = rz;
        end
      end
      @(negedge clk);
      lat++;
    end
    core_valid = 1'b0;
    if (!out_valid) lat = -1;
  endtask

  task automatic complete_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 0; in_mode = 0; in_x = 0; in_y = 0; in_z = 0;
    core_valid = 0; core_x_res = 0; core_y_res = 0; core_z_res = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, core_hold, out_valid, out_bypass, out_err, core_is_direct} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 110000",
               {in_ready, core_hold, out_valid, out_bypass, out_err, core_is_direct});
    end
    checks++;
    if ({out_x, out_y, out_z, core_x, core_y, core_z} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {out_x, out_y, out_z, core_x, core_y, core_z});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, core_hold, out_valid} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release got %b exp 110", {in_ready, core_hold, out_valid});
    end
  endtask

  task automatic test_rotation_core();
    bit acc, stable, busy, rel; int lat; logic [48:0] seen;
    out_ready = 1'b1;
    send_job(1'b1, 16'd8192, 16'd0, 16'd6434, acc);
    run_core(14, 16'd5795, 16'd5790, 16'd3, lat, seen, stable, busy, rel);
    checks++;
    if (!acc || lat != 16) begin
      errors++; $display("FAIL rot_latency got acc=%0d lat=%0d exp acc=1 lat=16", acc, lat);
    end
    checks++;
    if (seen !== {1'b1, 16'd8192, 16'd0, 16'd6434} || !stable || !busy) begin
      errors++;
      $display("FAIL rot_core_ops got %h stable=%0d busy=%0d exp %h stable=1 busy=1",
               seen, stable, busy, {1'b1, 16'd8192, 16'd0, 16'd6434});
    end
    checks++;
    if ({out_x, out_y, out_z, out_bypass, out_err, core_hold} !== {16'd5795, 16'd5790, 16'd3, 3'b001}) begin
      errors++;
      $display("FAIL rot_result got %h exp %h", {out_x, out_y, out_z, out_bypass, out_err, core_hold},
               {16'd5795, 16'd5790, 16'd3, 3'b001});
    end
    complete_out();
    checks++;
    if ({out_valid, in_ready, out_bypass, out_err} !== 4'b0100) begin
      errors++; $display("FAIL rot_handshake got %b exp 0100", {out_valid, in_ready, out_bypass, out_err});
    end
  endtask

  task automatic test_rotation_wrap();
    bit acc, stable, busy, rel; int lat; logic [48:0] seen;
    out_ready = 1'b1;
    send_job(1'b1, 16'd4096, 16'd2048, 16'd30000, acc);
    run_core(14, 16'd100, 16'd200, 16'd300, lat, seen, stable, busy, rel);
    checks++;
    if (lat != 16 || seen !== {1'b1, 16'd4096, 16'd2048, 16'(-21472)}) begin
      errors++;
      $display("FAIL wrap_core_z got lat=%0d ops=%h exp lat=16 ops=%h", lat, seen,
               {1'b1, 16'd4096, 16'd2048, 16'(-21472)});
    end
    checks++;
    if ({out_x, out_y, out_z} !== {16'd100, 16'd200, 16'd300}) begin
      errors++; $display("FAIL wrap_result got %h exp 006400c8012c", {out_x, out_y, out_z});
    end
    complete_out();
    send_job(1'b1, 16'd8192, 16'd4096, 16'(-25736), acc);
    run_core(0, 16'd0, 16'd0, 16'd0, lat, seen, stable, busy, rel);
    checks++;
    if (lat != 1 || rel) begin
      errors++; $display("FAIL neg_pi_latency got lat=%0d released=%0d exp lat=1 released=0", lat, rel);
    end
    checks++;
    if ({out_x, out_y, out_z, out_bypass, out_err, core_hold} !== {16'(-8192), 16'(-4096), 16'd0, 3'b101}) begin
      errors++;
      $display("FAIL neg_pi_result got %h exp %h", {out_x, out_y, out_z, out_bypass, out_err, core_hold},
               {16'(-8192), 16'(-4096), 16'd0, 3'b101});
    end
    complete_out();
    send_job(1'b1, 16'h8000, 16'd0, 16'd25736, acc);
    run_core(0, 16'd0, 16'd0, 16'd0, lat, seen, stable, busy, rel);
    checks++;
    if (lat != 1 || {out_x, out_y, out_z, out_bypass} !== {16'd32767, 16'd0, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL pos_pi_sat got lat=%0d out=%h exp lat=1 out=%h", lat, {out_x, out_y, out_z, out_bypass},
               {16'd32767, 16'd0, 16'd0, 1'b1});
    end
    complete_out();
  endtask

  task automatic test_vectoring_bypass();
    bit acc, stable, busy, rel; int lat; logic [48:0] seen;
    logic [15:0] tx [4];
    logic [15:0] ty [4];
    logic [47:0] te [4];
    tx = '{16'd0, 16'h8000, 16'd0, 16'd0};
    ty = '{16'd8192, 16'd0, 16'd0, 16'h8000};
    te = '{{16'd8192, 16'd0, 16'd12868}, {16'd32767, 16'd0, 16'd25736},
           48'd0, {16'd32767, 16'd0, 16'(-12868)}};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_job(1'b0, tx[i], ty[i], 16'd1000, acc);
      run_core(0, 16'd0, 16'd0, 16'd0, lat, seen, stable, busy, rel);
      checks++;
      if (lat != 1 || rel || {out_bypass, out_err, core_hold} !== 3'b101) begin
        errors++;
        $display("FAIL vec_bypass_flags[%0d] got lat=%0d rel=%0d flags=%b exp lat=1 rel=0 flags=101",
                 i, lat, rel, {out_bypass, out_err, core_hold});
      end
      checks++;
      if ({out_x, out_y, out_z} !== te[i]) begin
        errors++; $display("FAIL vec_bypass_result[%0d] got %h exp %h", i, {out_x, out_y, out_z}, te[i]);
      end
      complete_out();
    end
  endtask

  task automatic test_vectoring_core();
    bit acc, stable, busy, rel; int lat; logic [48:0] seen;
    out_ready = 1'b1;
    send_job(1'b0, 16'(-8192), 16'd8192, 16'd0, acc);
    run_core(14, 16'd11585, 16'd2, 16'd19302, lat, seen, stable, busy, rel);
    checks++;
    if (lat != 16 || seen !== {1'b0, 16'(-8192), 16'd8192, 16'd0} || !stable || !busy) begin
      errors++;
      $display("FAIL vec_core_ops got lat=%0d ops=%h stable=%0d busy=%0d exp lat=16 ops=%h stable=1 busy=1",
               lat, seen, stable, busy, {1'b0, 16'(-8192), 16'd8192, 16'd0});
    end
    checks++;
    if ({out_x, out_y, out_z, out_bypass, out_err} !== {16'd11585, 16'd2, 16'd19302, 2'b00}) begin
      errors++;
      $display("FAIL vec_core_result got %h exp %h", {out_x, out_y, out_z, out_bypass, out_err},
               {16'd11585, 16'd2, 16'd19302, 2'b00});
    end
    complete_out();
  endtask

  task automatic test_timeout();
    bit acc, stable, busy, rel; int lat; logic [48:0] seen;
    out_ready = 1'b0;
    send_job(1'b1, 16'd8192, 16'd0, 16'd6434, acc);
    run_core(0, 16'd0, 16'd0, 16'd0, lat, seen, stable, busy, rel);
    checks++;
    if (lat != 2 + TIMEOUT) begin
      errors++; $display("FAIL timeout_latency got %0d exp %0d", lat, 2 + TIMEOUT);
    end
    checks++;
    if ({out_x, out_y, out_z, out_bypass, out_err, core_hold} !== {48'd0, 3'b011}) begin
      errors++;
      $display("FAIL timeout_result got %h exp %h", {out_x, out_y, out_z, out_bypass, out_err, core_hold},
               {48'd0, 3'b011});
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_err, out_bypass, out_x, out_y, out_z} !== {4'b1010, 48'd0}) begin
        errors++;
        $display("FAIL timeout_stall[%0d] got %h exp %h", i,
                 {out_valid, in_ready, out_err, out_bypass, out_x, out_y, out_z}, {4'b1010, 48'd0});
      end
    end
    in_valid = 1'b0;
    complete_out();
    checks++;
    if ({out_valid, in_ready, out_err} !== 3'b010) begin
      errors++; $display("FAIL timeout_handshake got %b exp 010", {out_valid, in_ready, out_err});
    end
    send_job(1'b1, 16'd8192, 16'd0, 16'd6434, acc);
    run_core(TIMEOUT, 16'd7, 16'd8, 16'd9, lat, seen, stable, busy, rel);
    checks++;
    if (lat != 2 + TIMEOUT || {out_x, out_y, out_z, out_err} !== {16'd7, 16'd8, 16'd9, 1'b0}) begin
      errors++;
      $display("FAIL timeout_race got lat=%0d out=%h exp lat=%0d out=%h", lat, {out_x, out_y, out_z, out_err},
               2 + TIMEOUT, {16'd7, 16'd8, 16'd9, 1'b0});
    end
    complete_out();
  endtask

  task automatic test_reset_mid_wait();
    bit acc, stable, busy, rel; int lat; logic [48:0] seen;
    out_ready = 1'b1;
    send_job(1'b1, 16'd8192, 16'd0, 16'd6434, acc);
    repeat (4) @(negedge clk);
    checks++;
    if (core_hold !== 1'b0) begin
      errors++; $display("FAIL midwait_running got core_hold=%b exp 0", core_hold);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({core_hold, out_valid, in_ready, core_x} !== {3'b101, 16'd0}) begin
      errors++;
      $display("FAIL midwait_async_reset got %h exp %h", {core_hold, out_valid, in_ready, core_x},
               {3'b101, 16'd0});
    end
    @(negedge clk);
    reset = 1'b1;
    send_job(1'b1, 16'd8192, 16'd0, 16'd6434, acc);
    run_core(14, 16'd5793, 16'd5793, 16'd1, lat, seen, stable, busy, rel);
    checks++;
    if (!acc || lat != 16 || {out_x, out_y, out_z, out_err} !== {16'd5793, 16'd5793, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL midwait_fresh_job got acc=%0d lat=%0d out=%h exp acc=1 lat=16 out=%h", acc, lat,
               {out_x, out_y, out_z, out_err}, {16'd5793, 16'd5793, 16'd1, 1'b0});
    end
    complete_out();
  endtask

  initial begin
    test_reset();
    test_rotation_core();
    test_rotation_wrap();
    test_vectoring_bypass();
    test_vectoring_core();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
